// File: rtl/sensor_stream_receiver.sv
// -----------------------------------------------------------------------------
// sensor_stream_receiver
//
// Receiving end of a sensor row-output bus. The sensor word strobe (OUTPUT_CLK)
// and end-of-frame level (FRAME_FINISHED) are synchronised into the CLK domain
// and edge-detected. Each detected word is tagged with its row/frame position
// and pushed into a small FIFO whose head is presented on a valid/ready stream.
//
// Optional build macro: FRAME_CHECKSUM_EN
//   Adds CHECKSUM[15:0] / CHECKSUM_VALID, a per-frame sum of all accepted
//   pixels (mod 2^16), published on the frame-last write.
//
// Ports:
//   CLK             system clock, all state on rising edge
//   RESET           asynchronous active-low reset
//   OUTPUT_CLK      sensor word strobe (one word per rising edge)
//   DATA_IN         sensor word, pixel 0 in the LSBs
//   FRAME_FINISHED  sensor end-of-frame level
//   OUT_DATA        FIFO head word
//   OUT_VALID       FIFO non-empty
//   OUT_READY       downstream accept; pop on OUT_VALID && OUT_READY
//   OUT_ROW_LAST    head word is the last word of its row
//   OUT_FRAME_LAST  head word is the last word of the frame
//   OVERFLOW        sticky: a word was dropped on a full FIFO
//   FRAME_ERROR     sticky: frame boundary seen off position (0,0), or a word
//                   arrived after a completed frame before the next boundary
//   CLEAR_FLAGS     synchronous clear of OVERFLOW / FRAME_ERROR (set wins)
//   FRAME_COUNT     completed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module sensor_stream_receiver #(
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int OUTPUT_BUS_WIDTH   = 2,
  parameter int PIXEL_BITS         = 8,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   OUTPUT_CLK,
  input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] DATA_IN,
  input  logic                                   FRAME_FINISHED,
  output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] OUT_DATA,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic                                   OUT_ROW_LAST,
  output logic                                   OUT_FRAME_LAST,
  output logic                                   OVERFLOW,
  output logic                                   FRAME_ERROR,
  input  logic                                   CLEAR_FLAGS,
  output logic [7:0]                             FRAME_COUNT
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]                            CHECKSUM,
  output logic                                   CHECKSUM_VALID
`endif
);

  localparam int DW    = OUTPUT_BUS_WIDTH * PIXEL_BITS;
  localparam int WPR   = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
  localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WPR - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [2:0]       r_oclk_sync;
  logic [2:0]       r_ff_sync;
  logic             w_word_evt;
  logic             w_frame_evt;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_nxt;

  logic             w_accept;
  logic             w_row_last;
  logic             w_frame_last;
  logic             w_frame_err_evt;
  logic             w_done_word_err;

  logic [DW-1:0]    r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_rl;
  logic [FIFO_DEPTH-1:0] r_mem_fl;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;

  logic             r_overflow;
  logic             r_frame_error;
  logic [7:0]       r_frame_count;

  // ---------------------------------------------------------------------------
  // Input synchronisers: two flops for metastability, third for edge detect
  // ---------------------------------------------------------------------------
  // Shift the sensor strobe and frame level through their synchroniser chains
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_oclk_sync <= 3'b000;
      r_ff_sync   <= 3'b000;
    end else begin
      r_oclk_sync <= {r_oclk_sync[1:0], OUTPUT_CLK};
      r_ff_sync   <= {r_ff_sync[1:0], FRAME_FINISHED};
    end
  end

  assign w_word_evt  = r_oclk_sync[1] & ~r_oclk_sync[2];
  assign w_frame_evt = r_ff_sync[1] & ~r_ff_sync[2];

  // Position tags of the word arriving this cycle, from the current counters
  assign w_row_last   = (r_col == COL_MAX);
  assign w_frame_last = w_row_last && (r_row == ROW_MAX);

  // Words are only taken once a frame boundary has been seen
  assign w_accept = w_word_evt && (r_state != ST_SEEK);

  // ---------------------------------------------------------------------------
  // FSM / position counters
  // ---------------------------------------------------------------------------
  // State register and position counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_SEEK;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next state: the word (if any) is processed first with the old counters,
  // then the frame boundary rule is applied to the post-word position.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_frame_err_evt = 1'b0;
    w_done_word_err = 1'b0;

    if (w_accept) begin
      w_done_word_err = (r_state == ST_DONE);
      if (w_row_last) begin
        w_col_nxt = '0;
        if (w_frame_last) begin
          w_row_nxt   = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end else begin
      w_col_nxt = r_col;
    end

    if (w_frame_evt) begin
      case (w_state_nxt)
        ST_SEEK: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if ((w_col_nxt != '0) || (w_row_nxt != '0)) begin
            w_frame_err_evt = 1'b1;
            w_col_nxt       = '0;
            w_row_nxt       = '0;
          end else begin
            w_frame_err_evt = 1'b0;
          end
        end
        ST_DONE: w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_SEEK;
      endcase
    end else begin
      w_frame_err_evt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = OUT_VALID && OUT_READY;
  // A same-cycle pop frees the slot, so a write to a full FIFO still lands
  assign w_wr   = w_accept && (!w_full || w_pop);
  assign w_drop = w_accept && w_full && !w_pop;

  // Storage: word plus its row/frame-last tags
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
      end
      r_mem_rl <= '0;
      r_mem_fl <= '0;
    end else if (w_wr) begin
      r_mem_data[r_wptr] <= DATA_IN;
      r_mem_rl[r_wptr]   <= w_row_last;
      r_mem_fl[r_wptr]   <= w_frame_last;
    end else begin
      r_mem_rl <= r_mem_rl;
      r_mem_fl <= r_mem_fl;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr <= w_wr  ? r_wptr + 1'b1 : r_wptr;
      r_rptr <= w_pop ? r_rptr + 1'b1 : r_rptr;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign OUT_VALID      = (r_count != '0);
  assign OUT_DATA       = r_mem_data[r_rptr];
  assign OUT_ROW_LAST   = r_mem_rl[r_rptr];
  assign OUT_FRAME_LAST = r_mem_fl[r_rptr];

  // ---------------------------------------------------------------------------
  // Status flags and frame counter
  // ---------------------------------------------------------------------------
  // Sticky flags (set beats clear) and completed-frame counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (CLEAR_FLAGS) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end

      if (w_frame_err_evt || w_done_word_err) begin
        r_frame_error <= 1'b1;
      end else if (CLEAR_FLAGS) begin
        r_frame_error <= 1'b0;
      end else begin
        r_frame_error <= r_frame_error;
      end

      // A dropped frame-last word still completes the frame (alignment kept)
      if (w_accept && w_frame_last) begin
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_frame_count <= r_frame_count;
      end
    end
  end

  assign OVERFLOW    = r_overflow;
  assign FRAME_ERROR = r_frame_error;
  assign FRAME_COUNT = r_frame_count;

`ifdef FRAME_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Per-frame pixel checksum
  // ---------------------------------------------------------------------------
  logic [15:0] r_cks_acc;
  logic [15:0] r_checksum;
  logic        r_checksum_valid;
  logic [15:0] w_word_sum;

  // Sum of all pixels in one bus word, mod 2^16
  function automatic logic [15:0] f_word_sum(input logic [DW-1:0] word);
    logic [15:0] s;
    s = 16'd0;
    for (int p = 0; p < OUTPUT_BUS_WIDTH; p++) begin
      s = s + 16'(word[p*PIXEL_BITS +: PIXEL_BITS]);
    end
    return s;
  endfunction

  assign w_word_sum = w_wr ? f_word_sum(DATA_IN) : 16'd0;

  // Accumulate words written in RUN; publish and restart on the frame-last word
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cks_acc        <= 16'd0;
      r_checksum       <= 16'd0;
      r_checksum_valid <= 1'b0;
    end else begin
      r_checksum_valid <= 1'b0;
      if (w_frame_err_evt) begin
        r_cks_acc <= 16'd0;
      end else if (w_accept && w_frame_last && (r_state == ST_RUN)) begin
        r_checksum       <= r_cks_acc + w_word_sum;
        r_checksum_valid <= 1'b1;
        r_cks_acc        <= 16'd0;
      end else if (w_wr && (r_state == ST_RUN)) begin
        r_cks_acc <= r_cks_acc + w_word_sum;
      end else begin
        r_cks_acc <= r_cks_acc;
      end
    end
  end

  assign CHECKSUM       = r_checksum;
  assign CHECKSUM_VALID = r_checksum_valid;
`endif

endmodule

// File: doc/sensor_stream_receiver.md
Name: sensor_stream_receiver

Overview:
Receiving end of the sensor's row output bus. Samples the sensor-generated OUTPUT_CLK strobe, DATA_OUT words and FRAME_FINISHED in the system clock domain. Tags each word with row and frame position and buffers it in a small FIFO. Presents words on a valid/ready stream to downstream image processing or a frame store.

Parameters:
PIXEL_ARRAY_WIDTH, 4, pixels per row
PIXEL_ARRAY_HEIGHT, 4, rows per frame
OUTPUT_BUS_WIDTH, 2, pixels per bus word; PIXEL_ARRAY_WIDTH must be an integer multiple
PIXEL_BITS, 8, bits per pixel
FIFO_DEPTH, 4, word entries; power of two, >=2

Ports:
CLK  input  1  system clock; all state on rising edge
RESET  input  1  asynchronous, active-low reset
OUTPUT_CLK  input  1  sensor word strobe; each rising edge presents one new word
DATA_IN  input  OUTPUT_BUS_WIDTH*PIXEL_BITS  sensor word, pixel 0 in LSBs
FRAME_FINISHED  input  1  sensor end-of-frame level
OUT_DATA  output  OUTPUT_BUS_WIDTH*PIXEL_BITS  FIFO head word
OUT_VALID  output  1  FIFO non-empty
OUT_READY  input  1  downstream accepts; pop when OUT_VALID&&OUT_READY
OUT_ROW_LAST  output  1  head word is last word of its row
OUT_FRAME_LAST  output  1  head word is last word of the frame
OVERFLOW  output  1  sticky: word dropped on full FIFO
FRAME_ERROR  output  1  sticky: frame boundary arrived with position counters not at 0
CLEAR_FLAGS  input  1  synchronous clear of OVERFLOW and FRAME_ERROR
FRAME_COUNT  output  8  completed frames, wraps 255->0

Behaviour:
- Reset values: all outputs 0; FIFO empty; counters 0; FSM in SEEK.
- OUTPUT_CLK and FRAME_FINISHED each pass through a 2-flop synchronizer, followed by a rising-edge detector (3rd flop).
- word_evt = edge on OUTPUT_CLK; frame_evt = edge on FRAME_FINISHED.
- DATA_IN is captured on the word_evt cycle. The sensor holds DATA_IN stable for >=4 CLK cycles after its OUTPUT_CLK rise.
- Latency: OUTPUT_CLK rise to FIFO write takes 3 CLK cycles. OUT_VALID asserts on the following cycle if the FIFO was empty.
- WPR = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH. col counter runs 0..WPR-1; row counter runs 0..PIXEL_ARRAY_HEIGHT-1.
- Each written entry stores row_last = (col==WPR-1) and frame_last = row_last && (row==HEIGHT-1).
- FSM states:
  - SEEK: word_evt discarded, counters held at 0; frame_evt -> RUN.
  - RUN: word_evt writes the word, then col increments; at col==WPR-1, col wraps to 0 and row increments. A frame_last write wraps row to 0, increments FRAME_COUNT and moves the FSM to DONE.
  - DONE: word_evt handled as in RUN and FRAME_ERROR set; frame_evt -> RUN, no error.
- frame_evt in RUN with (row,col)!=(0,0): set FRAME_ERROR, zero the counters, stay in RUN.
- Simultaneous word_evt and frame_evt: the word is processed with the old counters first, then the frame_evt rule applies.
- FIFO full on write: word dropped, OVERFLOW set, counters still advance (alignment kept). If a pop happens in the same cycle, the write succeeds.
- Pop and push on an empty FIFO: no bypass; the pushed word appears the next cycle.
- CLEAR_FLAGS in the same cycle as a new set event: set wins.
- OUT_DATA, OUT_ROW_LAST and OUT_FRAME_LAST are don't-care while OUT_VALID=0.
- RESET mid-frame: immediate flush, FSM returns to SEEK.

Optional Feature:
FRAME_CHECKSUM_EN:
- Adds outputs CHECKSUM[15:0] and CHECKSUM_VALID.
- Running sum mod 2^16 of every pixel of every word accepted into the FIFO in RUN. Dropped words are excluded.
- On the frame_last write, CHECKSUM is loaded with the final sum, CHECKSUM_VALID pulses for 1 cycle, and the accumulator clears.
- Accumulator also clears on reset and on a frame_evt-with-error.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, frame_evt, then 8 words 0x0100..0x0807, OUT_READY=1 -> 8 outputs in order; ROW_LAST on words 2,4,6,8; FRAME_LAST on word 8; FRAME_COUNT=1.
2. 3 words before the first FRAME_FINISHED, then a full frame -> the first 3 words never appear; output is the 8-word frame only.
3. OUT_READY=0 for a full frame -> 4 words buffered, OVERFLOW=1 after word 5. Then OUT_READY=1 -> words 1-4 out, FRAME_COUNT still 1.
4. frame_evt after 5 words -> FRAME_ERROR=1, next word tagged col0/row0. CLEAR_FLAGS -> FRAME_ERROR=0.
5. RESET pulsed low mid-frame with 2 words queued -> OUT_VALID=0 immediately; SEEK until the next FRAME_FINISHED.
6. FRAME_CHECKSUM_EN, frame of all-0xFF pixels -> CHECKSUM=16*255=0x0FF0, CHECKSUM_VALID 1-cycle pulse aligned with the frame_last write.
